dram_arbiter: RTL and testbench

Single-port data-RAM arbiter that owns the DRAM port for the CPU core. It shares the port between three requesters: the data-fetch read port (highest priority, never stalled), the writeback write port (decoupled through a one-entry write buffer with read forwarding) and a host load/dump port (lowest priority, with a starvation guard). It issues pipeline holds only when a collision or a host starvation forces one.

---
 rtl/dram_arbiter_pkg.sv | 17 +
 rtl/dram_write_buffer.sv | 84 ++++++++
 rtl/dram_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_dram_arbiter.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dram_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dram_arbiter_pkg                                                      |
// | Shared host-port FSM encodings for the DRAM arbiter.                  |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package dram_arbiter_pkg;

  typedef enum logic [1:0] {
    HOST_IDLE  = 2'd0,
    HOST_WAIT  = 2'd1,
    HOST_FORCE = 2'd2,
    HOST_RESP  = 2'd3
  } host_state_t;

endpackage
`default_nettype wire

// File: rtl/dram_write_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dram_write_buffer                                                     |
// | One-entry write buffer: capture, coalesce, retire, read forwarding.   |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module dram_write_buffer #(
  parameter int A_WIDTH = 12,
  parameter int D_WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               rd_ce,
  input  logic [A_WIDTH-1:0] rd_a,
  input  logic               new_v,
  input  logic [A_WIDTH-1:0] new_a,
  input  logic [D_WIDTH-1:0] new_d,
  output logic               buf_v,
  output logic [A_WIDTH-1:0] buf_a,
  output logic [D_WIDTH-1:0] buf_d,
  output logic               retire,
  output logic               direct,
  output logic               stall,
  output logic               fwd_hit,
  output logic [D_WIDTH-1:0] fwd_d
);

  logic               r_buf_v;
  logic [A_WIDTH-1:0] r_buf_a;
  logic [D_WIDTH-1:0] r_buf_d;

  logic               w_wr_match;
  logic               w_capture;
  logic               w_coalesce;
  logic               w_nx_v;
  logic [A_WIDTH-1:0] w_nx_a;
  logic [D_WIDTH-1:0] w_nx_d;

  assign w_wr_match = (new_a == r_buf_a);

  // A read owns the port, so the buffer only retires on read-free cycles.
  assign retire     = r_buf_v & ~rd_ce;
  assign direct     = new_v & ~r_buf_v & ~rd_ce;
  assign stall      = new_v & r_buf_v & rd_ce & ~w_wr_match;
  assign w_capture  = new_v & (r_buf_v ? ~rd_ce : rd_ce);
  assign w_coalesce = new_v & r_buf_v & rd_ce & w_wr_match;

  always_comb begin
    w_nx_v = r_buf_v;
    w_nx_a = r_buf_a;
    w_nx_d = r_buf_d;
    if (w_capture) begin
      w_nx_v = 1'b1;
      w_nx_a = new_a;
      w_nx_d = new_d;
    end else if (w_coalesce) begin
      w_nx_d = new_d;
    end else if (retire) begin
      w_nx_v = 1'b0;
    end
  end

  // Forward from the post-update contents so a same-cycle write wins.
  assign fwd_hit = w_nx_v & (w_nx_a == rd_a);
  assign fwd_d   = w_nx_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_buf_v <= 1'b0;
      r_buf_a <= '0;
      r_buf_d <= '0;
    end else begin
      r_buf_v <= w_nx_v;
      r_buf_a <= w_nx_a;
      r_buf_d <= w_nx_d;
    end
  end

  assign buf_v = r_buf_v;
  assign buf_a = r_buf_a;
  assign buf_d = r_buf_d;

endmodule
`default_nettype wire

// File: rtl/dram_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dram_arbiter                                                          |
// | Single-port DRAM arbiter: fetch read, buffered writeback, host port.  |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module dram_arbiter
  import dram_arbiter_pkg::*;
#(
  parameter int A_WIDTH      = 12,
  parameter int D_WIDTH      = 8,
  parameter int STARVE_LIMIT = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               rd_ce,
  input  logic [A_WIDTH-1:0] rd_a,
  output logic [D_WIDTH-1:0] rd_d,
  input  logic               wr_ce,
  input  logic [A_WIDTH-1:0] wr_a,
  input  logic [D_WIDTH-1:0] wr_d,
  output logic               wr_stall,
  output logic               pipe_hold,
  input  logic               host_req,
  input  logic               host_we,
  input  logic [A_WIDTH-1:0] host_a,
  input  logic [D_WIDTH-1:0] host_wd,
  output logic               host_ack,
  output logic [D_WIDTH-1:0] host_rd,
  output logic               ram_ce,
  output logic               ram_we,
  output logic [A_WIDTH-1:0] ram_a,
  output logic [D_WIDTH-1:0] ram_d,
  input  logic [D_WIDTH-1:0] ram_q
);

  localparam int            CW      = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] C_LIMIT = CW'(STARVE_LIMIT);
  localparam logic [CW-1:0] C_ONE   = CW'(1);

  host_state_t        r_state;
  logic [CW-1:0]      r_cnt;
  logic               r_host_we;
  logic               r_pipe_hold;
  logic               r_coll;
  logic [A_WIDTH-1:0] r_pend_a;
  logic [D_WIDTH-1:0] r_pend_d;
  logic               r_rd_v;
  logic               r_fwd_v;
  logic [D_WIDTH-1:0] r_fwd_d;

  logic               w_new_v;
  logic [A_WIDTH-1:0] w_new_a;
  logic [D_WIDTH-1:0] w_new_d;
  logic               w_buf_v;
  logic [A_WIDTH-1:0] w_buf_a;
  logic [D_WIDTH-1:0] w_buf_d;
  logic               w_retire;
  logic               w_direct;
  logic               w_stall;
  logic               w_fwd_hit;
  logic [D_WIDTH-1:0] w_fwd_d;
  logic               w_host_grant;
  logic [CW-1:0]      w_cnt_inc;

  // A collided write is replayed from the pending latch during the hold cycle.
  assign w_new_v = r_coll | wr_ce;
  assign w_new_a = r_coll ? r_pend_a : wr_a;
  assign w_new_d = r_coll ? r_pend_d : wr_d;

  dram_write_buffer #(
    .A_WIDTH (A_WIDTH),
    .D_WIDTH (D_WIDTH)
  ) u_wbuf (
    .clk     (clk),
    .reset   (reset),
    .rd_ce   (rd_ce),
    .rd_a    (rd_a),
    .new_v   (w_new_v),
    .new_a   (w_new_a),
    .new_d   (w_new_d),
    .buf_v   (w_buf_v),
    .buf_a   (w_buf_a),
    .buf_d   (w_buf_d),
    .retire  (w_retire),
    .direct  (w_direct),
    .stall   (w_stall),
    .fwd_hit (w_fwd_hit),
    .fwd_d   (w_fwd_d)
  );

  assign w_host_grant = ((r_state == HOST_WAIT) || (r_state == HOST_FORCE)) &
                        ~rd_ce & ~w_buf_v & ~w_new_v;
  assign w_cnt_inc    = r_cnt + C_ONE;

  always_comb begin
    ram_ce = 1'b0;
    ram_we = 1'b0;
    ram_a  = '0;
    ram_d  = '0;
    if (rd_ce) begin
      ram_ce = 1'b1;
      ram_a  = rd_a;
    end else if (w_retire) begin
      ram_ce = 1'b1;
      ram_we = 1'b1;
      ram_a  = w_buf_a;
      ram_d  = w_buf_d;
    end else if (w_direct) begin
      ram_ce = 1'b1;
      ram_we = 1'b1;
      ram_a  = w_new_a;
      ram_d  = w_new_d;
    end else if (w_host_grant) begin
      ram_ce = 1'b1;
      ram_we = host_we;
      ram_a  = host_a;
      ram_d  = host_we ? host_wd : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_coll   <= 1'b0;
      r_pend_a <= '0;
      r_pend_d <= '0;
      r_rd_v   <= 1'b0;
      r_fwd_v  <= 1'b0;
      r_fwd_d  <= '0;
    end else begin
      r_coll  <= w_stall;
      if (w_stall) begin
        r_pend_a <= wr_a;
        r_pend_d <= wr_d;
      end
      r_rd_v  <= rd_ce;
      r_fwd_v <= rd_ce & w_fwd_hit;
      r_fwd_d <= w_fwd_d;
    end
  end

  // Host FSM; pipe_hold covers both collision replays and forced host slots.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= HOST_IDLE;
      r_cnt       <= '0;
      r_host_we   <= 1'b0;
      r_pipe_hold <= 1'b0;
    end else begin
      r_pipe_hold <= w_stall;
      case (r_state)
        HOST_IDLE: begin
          r_cnt <= '0;
          if (host_req) r_state <= HOST_WAIT;
        end
        HOST_WAIT: begin
          if (w_host_grant) begin
            r_state   <= HOST_RESP;
            r_host_we <= host_we;
          end else begin
            r_cnt <= w_cnt_inc;
            if (w_cnt_inc == C_LIMIT) begin
              r_state     <= HOST_FORCE;
              r_pipe_hold <= 1'b1;
            end
          end
        end
        HOST_FORCE: begin
          if (w_host_grant) begin
            r_state   <= HOST_RESP;
            r_host_we <= host_we;
          end else begin
            r_pipe_hold <= 1'b1;
          end
        end
        HOST_RESP: begin
          r_cnt   <= '0;
          r_state <= HOST_IDLE;
        end
        default: r_state <= HOST_IDLE;
      endcase
    end
  end

  assign rd_d      = r_fwd_v ? r_fwd_d : (r_rd_v ? ram_q : '0);
  assign wr_stall  = w_stall;
  assign pipe_hold = r_pipe_hold;
  assign host_ack  = (r_state == HOST_RESP);
  assign host_rd   = ((r_state == HOST_RESP) && !r_host_we) ? ram_q : '0;

endmodule
`default_nettype wire

// File: tb/tb_dram_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_dram_arbiter                                                       |
// | Directed self-checking bench with a behavioural single-port RAM.      |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_dram_arbiter;

  logic        clk;
  logic        reset;
  logic        rd_ce;
  logic [11:0] rd_a;
  logic [7:0]  rd_d;
  logic        wr_ce;
  logic [11:0] wr_a;
  logic [7:0]  wr_d;
  logic        wr_stall;
  logic        pipe_hold;
  logic        host_req;
  logic        host_we;
  logic [11:0] host_a;
  logic [7:0]  host_wd;
  logic        host_ack;
  logic [7:0]  host_rd;
  logic        ram_ce;
  logic        ram_we;
  logic [11:0] ram_a;
  logic [7:0]  ram_d;
  logic [7:0]  ram_q;

  logic [7:0]  mem [0:4095];
  int          n_checks;
  int          n_errors;

  dram_arbiter #(
    .A_WIDTH      (12),
    .D_WIDTH      (8),
    .STARVE_LIMIT (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rd_ce     (rd_ce),
    .rd_a      (rd_a),
    .rd_d      (rd_d),
    .wr_ce     (wr_ce),
    .wr_a      (wr_a),
    .wr_d      (wr_d),
    .wr_stall  (wr_stall),
    .pipe_hold (pipe_hold),
    .host_req  (host_req),
    .host_we   (host_we),
    .host_a    (host_a),
    .host_wd   (host_wd),
    .host_ack  (host_ack),
    .host_rd   (host_rd),
    .ram_ce    (ram_ce),
    .ram_we    (ram_we),
    .ram_a     (ram_a),
    .ram_d     (ram_d),
    .ram_q     (ram_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_ce && !ram_we) ram_q <= mem[ram_a];
    if (ram_ce && ram_we)  mem[ram_a] <= ram_d;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rd_ce = 1'b0; wr_ce = 1'b0; host_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int  lat;
    int  holds;
    int  acks;
    bit  got;
    logic [7:0] hrd;

    n_checks = 0;
    n_errors = 0;
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    mem[12'h010] = 8'h5A;
    mem[12'h011] = 8'hA5;
    mem[12'h100] = 8'hC3;
    ram_q   = 8'h00;
    reset   = 1'b1;
    rd_a    = '0; wr_a = '0; wr_d = '0;
    host_we = 1'b0; host_a = '0; host_wd = '0;
    idle_inputs();
    tick(); tick();

    check("reset rd_d", rd_d, 8'h00);
    check("reset pipe_hold", pipe_hold, 1'b0);
    check("reset host_ack", host_ack, 1'b0);
    check("reset host_rd", host_rd, 8'h00);
    check("reset ram_ce", ram_ce, 1'b0);
    check("reset wr_stall", wr_stall, 1'b0);
    reset = 1'b0;
    tick();

    // Read-only stream
    rd_ce = 1'b1; rd_a = 12'h010;
    #1 check("rd0 ram_ce", ram_ce, 1'b1);
    check("rd0 ram_we", ram_we, 1'b0);
    tick();
    check("rd0 rd_d", rd_d, 8'h5A);
    rd_a = 12'h011;
    tick();
    check("rd1 rd_d", rd_d, 8'hA5);
    check("rd1 pipe_hold", pipe_hold, 1'b0);
    rd_ce = 1'b0;
    tick();
    check("rd idle rd_d", rd_d, 8'h00);

    // Read + write: write buffered, forwarded, then retired
    rd_ce = 1'b1; rd_a = 12'h020; wr_ce = 1'b1; wr_a = 12'h030; wr_d = 8'h11;
    #1 check("buf cap stall", wr_stall, 1'b0);
    check("buf cap ram_we", ram_we, 1'b0);
    tick();
    wr_ce = 1'b0; rd_a = 12'h030;
    tick();
    check("fwd rd_d", rd_d, 8'h11);
    check("fwd mem untouched", mem[12'h030], 8'h00);
    rd_ce = 1'b0;
    #1 check("retire ram_we", ram_we, 1'b1);
    check("retire ram_a", ram_a, 12'h030);
    check("retire ram_d", ram_d, 8'h11);
    tick();
    check("retire mem", mem[12'h030], 8'h11);

    // Collision: buffer 0x030, then read + write 0x040
    rd_ce = 1'b1; rd_a = 12'h020; wr_ce = 1'b1; wr_a = 12'h030; wr_d = 8'h12;
    tick();
    rd_a = 12'h021; wr_a = 12'h040; wr_d = 8'h22;
    #1 check("coll wr_stall", wr_stall, 1'b1);
    tick();
    check("coll pipe_hold", pipe_hold, 1'b1);
    rd_ce = 1'b0; wr_ce = 1'b0;
    #1 check("hold retire ram_a", ram_a, 12'h030);
    check("hold retire ram_we", ram_we, 1'b1);
    tick();
    check("hold released", pipe_hold, 1'b0);
    check("held write buffered", mem[12'h040], 8'h00);
    check("hold mem 030", mem[12'h030], 8'h12);
    #1 check("late retire ram_a", ram_a, 12'h040);
    check("late retire ram_d", ram_d, 8'h22);
    tick();
    check("late retire mem", mem[12'h040], 8'h22);
    check("single hold cycle", pipe_hold, 1'b0);

    // Coalesce: buffer 0x030<-0x11, then read + write 0x030<-0x33
    rd_ce = 1'b1; rd_a = 12'h020; wr_ce = 1'b1; wr_a = 12'h030; wr_d = 8'h11;
    tick();
    rd_a = 12'h030; wr_d = 8'h33;
    #1 check("coal wr_stall", wr_stall, 1'b0);
    tick();
    check("coal same-cycle fwd", rd_d, 8'h33);
    wr_ce = 1'b0;
    tick();
    check("coal fwd", rd_d, 8'h33);
    check("coal pipe_hold", pipe_hold, 1'b0);
    rd_ce = 1'b0;
    #1 check("coal retire ram_d", ram_d, 8'h33);
    tick();
    check("coal mem", mem[12'h030], 8'h33);

    // Host write on an idle port
    host_req = 1'b1; host_we = 1'b1; host_a = 12'h200; host_wd = 8'h77;
    got = 0; lat = 0; hrd = 8'hFF;
    for (int k = 1; k <= 20 && !got; k++) begin
      tick();
      if (host_ack) begin got = 1; lat = k; hrd = host_rd; end
    end
    host_req = 1'b0;
    check("hwr ack seen", got, 1'b1);
    check("hwr latency", lat, 2);
    check("hwr host_rd", hrd, 8'h00);
    check("hwr mem", mem[12'h200], 8'h77);
    tick();

    // Host read under continuous fetch reads: forced slot
    host_req = 1'b1; host_we = 1'b0; host_a = 12'h100;
    rd_ce = 1'b1; rd_a = 12'h010;
    got = 0; lat = 0; holds = 0; hrd = 8'h00;
    for (int k = 1; k <= 20 && !got; k++) begin
      tick();
      if (pipe_hold) holds++;
      if (host_ack) begin got = 1; lat = k; hrd = host_rd; end
      rd_ce = !pipe_hold;
    end
    host_req = 1'b0; rd_ce = 1'b0;
    check("force ack seen", got, 1'b1);
    check("force latency", lat, 10);
    check("force host_rd", hrd, 8'hC3);
    check("force hold cycles", holds, 1);
    tick();

    // Reset with buffer full and host waiting
    rd_ce = 1'b1; rd_a = 12'h020; wr_ce = 1'b1; wr_a = 12'h050; wr_d = 8'h99;
    host_req = 1'b1; host_we = 1'b1; host_a = 12'h060; host_wd = 8'h44;
    tick();
    wr_ce = 1'b0;
    reset = 1'b1;
    tick();
    idle_inputs();
    tick();
    check("rst2 rd_d", rd_d, 8'h00);
    check("rst2 pipe_hold", pipe_hold, 1'b0);
    check("rst2 host_ack", host_ack, 1'b0);
    check("rst2 host_rd", host_rd, 8'h00);
    check("rst2 ram_ce", ram_ce, 1'b0);
    check("rst2 ram_we", ram_we, 1'b0);
    check("rst2 wr_stall", wr_stall, 1'b0);
    reset = 1'b0;
    acks = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (host_ack) acks++;
    end
    check("rst2 no host_ack", acks, 0);
    check("rst2 buffer dropped", mem[12'h050], 8'h00);
    check("rst2 host write dropped", mem[12'h060], 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
